// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared FSM state encoding, bus event bundle and width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_slave_pkg;

  localparam int I2C_ADDR_WIDTH_DEF = 7;
  localparam int I2C_DATA_WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_ACK,
    WR_DATA,
    RD_DATA,
    RD_ACK,
    RD_DONE,
    IGNORE
  } slv_state_e;

  // Bus conditions decoded from the synchronised SCL/SDA pair.
  typedef struct packed {
    logic start;
    logic stop;
    logic rise;
    logic fall;
  } bus_evt_t;

endpackage

// File: rtl/i2c_slave_engine.sv
// i2c_slave_engine: one I2C slave channel (synchroniser, FSM, auto-increment pointer, register file).
// Latency: bus events act 3 clk_i cycles after the pins; SDA changes only on the detected SCL fall.
// Backpressure: none by default; with I2C_SLAVE_CLK_STRETCH_EN SCL is held low after each ACK phase.
module i2c_slave_engine
  import i2c_slave_pkg::*;
#(
  parameter int            AW             = I2C_ADDR_WIDTH_DEF,
  parameter int            DW             = I2C_DATA_WIDTH_DEF,
  parameter logic [AW-1:0] SLAVE_ADDR     = 7'h22,
  parameter int            DEPTH          = 16,
  parameter int            STRETCH_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_drive_o,
  output logic scl_drive_o,
  output logic wr_evt_o,
  output logic busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DW + 1);

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;
  bus_evt_t ev;

  slv_state_e        state_q, state_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_q, sda_d;
  logic              busy_q, busy_d;
  logic              wr_evt_q, wr_evt_d;
  logic              mem_we;
  logic [DW-1:0]     shift_in;
  logic [DW-1:0]     rd_byte;
  logic [DW-1:0]     mem_q [DEPTH];

  // Two-flop synchroniser plus a previous copy for edge detection; idle bus reads high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  // Decode START/STOP (SDA moving while SCL stays high) and SCL edges.
  always_comb begin
    ev.start = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    ev.stop  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    ev.rise  = scl_s2_q & ~scl_prev_q;
    ev.fall  = ~scl_s2_q & scl_prev_q;
  end

  assign shift_in = {shift_q[DW-2:0], sda_s2_q};
  assign rd_byte  = mem_q[ptr_q];

  // Next-state logic; START beats everything so a half-shifted byte is simply dropped.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    sda_d    = sda_q;
    busy_d   = busy_q;
    wr_evt_d = 1'b0;
    mem_we   = 1'b0;
    if (ev.start) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_d    = 1'b0;
    end else if (ev.stop) begin
      state_d = IDLE;
      sda_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (ev.rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q + CW'(1);
          if (bitcnt_q == CW'(DW - 1)) begin
            if (shift_in[DW-1 -: AW] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = shift_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        // First fall after bit 8 pulls SDA low; the fall ending bit 9 leaves the ACK.
        ADDR_ACK, WR_ACK: if (ev.fall) begin
          if (!sda_q) begin
            sda_d = 1'b1;
          end else if (state_q == ADDR_ACK && rw_q) begin
            shift_d  = {rd_byte[DW-2:0], 1'b0};
            sda_d    = ~rd_byte[DW-1];
            bitcnt_d = CW'(1);
            state_d  = RD_DATA;
          end else begin
            sda_d    = 1'b0;
            bitcnt_d = '0;
            state_d  = (state_q == WR_ACK) ? WR_DATA : WR_PTR;
          end
        end
        WR_PTR, WR_DATA: if (ev.rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q + CW'(1);
          if (bitcnt_q == CW'(DW - 1)) begin
            state_d = WR_ACK;
            if (state_q == WR_PTR) begin
              ptr_d = shift_in[PW-1:0];
            end else begin
              mem_we   = 1'b1;
              wr_evt_d = 1'b1;
              ptr_d    = ptr_q + PW'(1);
            end
          end
        end
        // bitcnt 0 means "load the next byte on this fall"; DW means all bits are out.
        RD_DATA: if (ev.fall) begin
          if (bitcnt_q == '0) begin
            shift_d  = {rd_byte[DW-2:0], 1'b0};
            sda_d    = ~rd_byte[DW-1];
            bitcnt_d = CW'(1);
          end else if (bitcnt_q == CW'(DW)) begin
            sda_d   = 1'b0;
            ptr_d   = ptr_q + PW'(1);
            state_d = RD_ACK;
          end else begin
            sda_d    = ~shift_q[DW-1];
            shift_d  = {shift_q[DW-2:0], 1'b0};
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
        RD_ACK: if (ev.rise) begin
          if (sda_s2_q) begin
            state_d = RD_DONE;
          end else begin
            bitcnt_d = '0;
            state_d  = RD_DATA;
          end
        end
        IDLE, RD_DONE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, pointer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      sda_q    <= 1'b0;
      busy_q   <= 1'b0;
      wr_evt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
      wr_evt_q <= wr_evt_d;
    end
  end

  // Register file: cleared by reset, written at the pointer on each completed data byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_q] <= shift_d;
    end
  end

  assign sda_drive_o = sda_q;
  assign wr_evt_o    = wr_evt_q;
  assign busy_o      = busy_q;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  logic [SW-1:0] stretch_q;
  logic          ack_end;

  // The SCL fall that closes bit 9 of an ACKed byte.
  always_comb begin
    ack_end = ev.fall & ~ev.start & ~ev.stop &
              ((((state_q == ADDR_ACK) || (state_q == WR_ACK)) && sda_q) ||
               ((state_q == RD_DATA) && (bitcnt_q == '0)));
  end

  // Hold SCL low for STRETCH_CYCLES clocks after each ACK phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stretch_q <= '0;
    end else if (ack_end) begin
      stretch_q <= SW'(STRETCH_CYCLES);
    end else if (stretch_q != '0) begin
      stretch_q <= stretch_q - SW'(1);
    end
  end

  assign scl_drive_o = (stretch_q != '0);
`else
  assign scl_drive_o = 1'b0;
`endif

endmodule

// File: rtl/i2c_multi_slave_regfile.sv
// i2c_multi_slave_regfile: NUM_I2C_BUSSES independent I2C slave register files (optional I2C_SLAVE_CLK_STRETCH_EN).
// Latency: each channel reacts 3 clk_i cycles after its pins.
// Backpressure: none by default; with I2C_SLAVE_CLK_STRETCH_EN each channel stretches SCL after ACK phases.
module i2c_multi_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter int                        NUM_I2C_BUSSES = 1,
  parameter int                        I2C_ADDR_WIDTH = I2C_ADDR_WIDTH_DEF,
  parameter int                        I2C_DATA_WIDTH = I2C_DATA_WIDTH_DEF,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
  parameter int                        DEPTH          = 16,
  parameter int                        STRETCH_CYCLES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_I2C_BUSSES-1:0] scl_i,
  input  logic [NUM_I2C_BUSSES-1:0] sda_i,
  output logic [NUM_I2C_BUSSES-1:0] sda_drive_o,
  output logic [NUM_I2C_BUSSES-1:0] scl_drive_o,
  output logic [NUM_I2C_BUSSES-1:0] wr_evt_o,
  output logic [NUM_I2C_BUSSES-1:0] busy_o
);

  for (genvar g = 0; g < NUM_I2C_BUSSES; g++) begin : g_bus
    i2c_slave_engine #(
      .AW             (I2C_ADDR_WIDTH),
      .DW             (I2C_DATA_WIDTH),
      .SLAVE_ADDR     (SLAVE_ADDR),
      .DEPTH          (DEPTH),
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_engine (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .scl_i       (scl_i[g]),
      .sda_i       (sda_i[g]),
      .sda_drive_o (sda_drive_o[g]),
      .scl_drive_o (scl_drive_o[g]),
      .wr_evt_o    (wr_evt_o[g]),
      .busy_o      (busy_o[g])
    );
  end

endmodule
